wb_write_queue: RTL and testbench

Write-back queue that owns the register-file write port (`wrt_data`, `rd`, `RegWrite`). It sits between the pipeline's completion point (MEM/WB results) and the register file. Completed results are buffered in an in-order FIFO and drained one per cycle into the register file. The block also reports, to decode, which source registers still have writes pending and, optionally, their youngest pending values.

---
 rtl/wb_write_queue.sv | 139 +++++++++++++
 tb/tb_wb_write_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// In-order write-back queue owning the register-file write port, with pending-register lookup.
// Forwarding of the youngest pending value is built only when WB_FWD_EN is defined.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int AW    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_rd,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     drain_en,
  output logic [XLEN-1:0]          wrt_data,
  output logic [AW-1:0]            rd,
  output logic                     RegWrite,
  input  logic [AW-1:0]            rs1,
  input  logic [AW-1:0]            rs2,
  output logic                     pend1,
  output logic                     pend2,
  output logic [XLEN-1:0]          fwd_data1,
  output logic [XLEN-1:0]          fwd_data2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]   rd_q   [DEPTH];
  logic [AW-1:0]   rd_d   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic push, pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    in_ready = !full;
    // x0 results complete the handshake but are never stored
    push     = in_valid && in_ready && (in_rd != '0);
    pop      = !empty && drain_en;
    RegWrite = pop;
    rd       = empty ? '0 : rd_q[head_q];
    wrt_data = empty ? '0 : data_q[head_q];
    count    = count_q;
  end

  always_comb begin
    rd_d    = rd_q;
    data_d  = data_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (push) begin
      rd_d[tail_q]    = in_rd;
      data_d[tail_q]  = in_data;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only observed through valid bits and the empty flag
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (rd_q[i] == rs1) && (rs1 != '0)) pend1 = 1'b1;
      if (valid_q[i] && (rd_q[i] == rs2) && (rs2 != '0)) pend2 = 1'b1;
    end
  end

`ifdef WB_FWD_EN
  // Walk oldest to youngest so the last match is the youngest pending value
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (rd_q[idx] == rs1) && (rs1 != '0)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = data_q[idx];
      end
      if (valid_q[idx] && (rd_q[idx] == rs2) && (rs2 != '0)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = data_q[idx];
      end
    end
  end
`else
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: queue-level reference model checked every cycle plus directed scenarios.
module tb_wb_write_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
  localparam int AW    = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_rd;
  logic [XLEN-1:0] in_data;
  logic            drain_en;
  logic [XLEN-1:0] wrt_data;
  logic [AW-1:0]   rd;
  logic            RegWrite;
  logic [AW-1:0]   rs1, rs2;
  logic            pend1, pend2;
  logic [XLEN-1:0] fwd_data1, fwd_data2;
  logic            fwd_hit1, fwd_hit2;
  logic [2:0]      count;
  logic            full, empty;

  wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .drain_en(drain_en),
    .wrt_data(wrt_data), .rd(rd), .RegWrite(RegWrite),
    .rs1(rs1), .rs2(rs2), .pend1(pend1), .pend2(pend2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t mq[$];
  ent_t dut_log[$];
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: ordered list of outstanding writes
  always @(posedge clk) begin
    int sz;
    bit do_push;
    if (rst) mq.delete();
    else begin
      sz = mq.size();
      do_push = in_valid && (sz < DEPTH) && (in_rd != 0);
      if (sz > 0 && drain_en) void'(mq.pop_front());
      if (do_push) mq.push_back('{rd: in_rd, data: in_data});
    end
  end

  always @(negedge clk) begin
    int sz;
    logic e_p1, e_p2, e_h1, e_h2;
    logic [XLEN-1:0] e_f1, e_f2;
    if (chk_en) begin
      sz = mq.size();
      e_p1 = 0; e_p2 = 0; e_h1 = 0; e_h2 = 0; e_f1 = 0; e_f2 = 0;
      foreach (mq[k]) begin
        if (rs1 != 0 && mq[k].rd == rs1) e_p1 = 1;
        if (rs2 != 0 && mq[k].rd == rs2) e_p2 = 1;
      end
`ifdef WB_FWD_EN
      for (int k = sz - 1; k >= 0; k--) begin
        if (!e_h1 && rs1 != 0 && mq[k].rd == rs1) begin e_h1 = 1; e_f1 = mq[k].data; end
        if (!e_h2 && rs2 != 0 && mq[k].rd == rs2) begin e_h2 = 1; e_f2 = mq[k].data; end
      end
`endif
      chk("cyc_count", count, sz);
      chk("cyc_empty", empty, sz == 0);
      chk("cyc_full", full, sz == DEPTH);
      chk("cyc_in_ready", in_ready, sz != DEPTH);
      chk("cyc_regwrite", RegWrite, (sz != 0) && drain_en);
      chk("cyc_rd", rd, (sz == 0) ? 0 : mq[0].rd);
      chk("cyc_wrt_data", wrt_data, (sz == 0) ? 0 : mq[0].data);
      chk("cyc_pend", {pend1, pend2}, {e_p1, e_p2});
      chk("cyc_fwd_hit", {fwd_hit1, fwd_hit2}, {e_h1, e_h2});
      chk("cyc_fwd_data1", fwd_data1, e_f1);
      chk("cyc_fwd_data2", fwd_data2, e_f2);
      if (RegWrite) dut_log.push_back('{rd: rd, data: wrt_data});
    end
  end

  task automatic drive(input logic v, input logic [AW-1:0] r, input logic [XLEN-1:0] d, input logic de);
    in_valid = v; in_rd = r; in_data = d; drain_en = de;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; rs1 = 0; rs2 = 0;
    drive(0, 0, 0, 0);
    tick; tick;
    rst = 0;
    chk_en = 1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_regwrite", RegWrite, 0);

    // Single result
    drive(1, 5, -64'sd7, 1);
    tick;
    drive(0, 0, 0, 1);
    #1;
    chk("single_regwrite", RegWrite, 1);
    chk("single_rd", rd, 5);
    chk("single_data", wrt_data, 64'hFFFF_FFFF_FFFF_FFF9);
    tick;
    chk("single_empty_after", empty, 1);

    // Fill and drain
    for (int k = 0; k < 4; k++) begin
      drive(1, AW'(11 + k), 64'(100 + k), 0);
      tick;
    end
    drive(1, 15, 555, 0);
    #1;
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", count, 4);
    tick;
    chk("fill_5th_rejected", count, 4);
    dut_log.delete();
    drive(0, 0, 0, 1);
    tick;
    chk("drain_ready_after_pop", in_ready, 1);
    chk("drain_count_after_pop", count, 3);
    tick; tick; tick;
    drive(0, 0, 0, 0);
    tick;
    chk("drain_log_size", dut_log.size(), 4);
    for (int k = 0; k < 4 && k < dut_log.size(); k++) begin
      chk("drain_log_rd", dut_log[k].rd, 11 + k);
      chk("drain_log_data", dut_log[k].data, 100 + k);
    end

    // Streaming with wrap
    dut_log.delete();
    for (int k = 1; k <= 10; k++) begin
      drive(1, AW'(k), 64'(k * 3), 1);
      #1;
      chk("stream_count_le1", count <= 1, 1);
      tick;
    end
    drive(0, 0, 0, 1);
    tick; tick;
    chk("stream_log_size", dut_log.size(), 10);
    for (int k = 0; k < 10 && k < dut_log.size(); k++) begin
      chk("stream_log_rd", dut_log[k].rd, k + 1);
      chk("stream_log_data", dut_log[k].data, (k + 1) * 3);
    end

    // x0 discard
    dut_log.delete();
    drive(1, 0, 99, 1);
    #1;
    chk("x0_in_ready", in_ready, 1);
    tick;
    drive(0, 0, 0, 1);
    #1;
    chk("x0_count", count, 0);
    chk("x0_regwrite", RegWrite, 0);
    tick;
    chk("x0_no_write", dut_log.size(), 0);

    // Pending and forwarding
    drive(1, 3, 10, 0); tick;
    drive(1, 3, 20, 0); tick;
    drive(0, 0, 0, 0);
    rs1 = 3; rs2 = 4;
    #1;
    chk("pend1", pend1, 1);
    chk("pend2", pend2, 0);
`ifdef WB_FWD_EN
    chk("fwd_hit1", fwd_hit1, 1);
    chk("fwd_data1", fwd_data1, 20);
`else
    chk("fwd_hit1", fwd_hit1, 0);
    chk("fwd_data1", fwd_data1, 0);
`endif
    tick;
    drive(0, 0, 0, 1);
    #1;
    chk("pend_while_popping", pend1, 1);
    tick; tick;
    chk("pend_cleared", pend1, 0);
    rs1 = 0; rs2 = 0;

    // Reset mid-operation
    drive(1, 7, 70, 0); tick;
    drive(1, 8, 80, 0); tick;
    drive(1, 9, 90, 0); tick;
    chk("midrst_count_before", count, 3);
    dut_log.delete();
    rst = 1;
    drive(1, 10, 100, 0);
    tick;
    rst = 0;
    drive(0, 0, 0, 1);
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_regwrite", RegWrite, 0);
    tick; tick; tick;
    chk("midrst_no_write", dut_log.size(), 0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
